// File: rtl/vga_timing_if.sv
// Scan-position and sync bundle from the raster timing generator to the draw
// stages and game-update logic.
interface vga_timing_if;
  logic [10:0] xPosition;
  logic [9:0]  yPosition;
  logic        hSync;
  logic        vSync;
  logic        displayEnable;
  logic        lineStart;
  logic        frameStart;
  logic [7:0]  frameCount;

  modport master (
    output xPosition, yPosition, hSync, vSync, displayEnable, lineStart, frameStart, frameCount
  );

  modport slave (
    input xPosition, yPosition, hSync, vSync, displayEnable, lineStart, frameStart, frameCount
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Raster timing generator: free-running h/v counters with region FSMs (stage 1)
// feeding a registered decode (stage 2) so every output describes the same pixel.
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE  = 800,
  parameter int unsigned H_FRONT    = 40,
  parameter int unsigned H_SYNC     = 128,
  parameter int unsigned H_BACK     = 88,
  parameter int unsigned V_VISIBLE  = 600,
  parameter int unsigned V_FRONT    = 1,
  parameter int unsigned V_SYNC     = 4,
  parameter int unsigned V_BACK     = 23,
  parameter bit          H_SYNC_POL = 1'b1,
  parameter bit          V_SYNC_POL = 1'b1
) (
  input  logic         pixelClock,
  input  logic         Reset,
  vga_timing_if.master vga
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // Last count of each region; the FSM leaves the region on that count.
  localparam logic [10:0] H_ACT_END  = 11'(H_VISIBLE - 1);
  localparam logic [10:0] H_FP_END   = 11'(H_VISIBLE + H_FRONT - 1);
  localparam logic [10:0] H_SYNC_END = 11'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [9:0]  V_ACT_END  = 10'(V_VISIBLE - 1);
  localparam logic [9:0]  V_FP_END   = 10'(V_VISIBLE + V_FRONT - 1);
  localparam logic [9:0]  V_SYNC_END = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);

  typedef enum logic [1:0] {StActive, StFront, StSync, StBack} region_e;

  logic [10:0] r_h_cnt;
  logic [9:0]  r_v_cnt;
  region_e     r_h_state;
  region_e     r_v_state;

  logic [10:0] r_x;
  logic [9:0]  r_y;
  logic        r_hsync;
  logic        r_vsync;
  logic        r_de;
  logic        r_line_start;
  logic        r_frame_start;
  logic [7:0]  r_frame_count;

  logic w_h_wrap;
  logic w_v_wrap;
  logic w_frame_start;

  assign w_h_wrap      = (r_h_cnt == H_LAST);
  assign w_v_wrap      = (r_v_cnt == V_LAST);
  assign w_frame_start = (r_h_cnt == 11'd0) && (r_v_cnt == 10'd0);

  always_ff @(posedge pixelClock or negedge Reset) begin
    if (!Reset) begin
      r_h_cnt       <= '0;
      r_v_cnt       <= '0;
      r_h_state     <= StActive;
      r_v_state     <= StActive;
      r_x           <= '0;
      r_y           <= '0;
      r_hsync       <= ~H_SYNC_POL;
      r_vsync       <= ~V_SYNC_POL;
      r_de          <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_h_cnt <= w_h_wrap ? 11'd0 : r_h_cnt + 11'd1;
      if (w_h_wrap) begin
        r_v_cnt <= w_v_wrap ? 10'd0 : r_v_cnt + 10'd1;
      end

      unique case (r_h_state)
        StActive: if (r_h_cnt == H_ACT_END)  r_h_state <= StFront;
        StFront:  if (r_h_cnt == H_FP_END)   r_h_state <= StSync;
        StSync:   if (r_h_cnt == H_SYNC_END) r_h_state <= StBack;
        StBack:   if (w_h_wrap)              r_h_state <= StActive;
        default:                             r_h_state <= StActive;
      endcase

      if (w_h_wrap) begin
        unique case (r_v_state)
          StActive: if (r_v_cnt == V_ACT_END)  r_v_state <= StFront;
          StFront:  if (r_v_cnt == V_FP_END)   r_v_state <= StSync;
          StSync:   if (r_v_cnt == V_SYNC_END) r_v_state <= StBack;
          StBack:   if (w_v_wrap)              r_v_state <= StActive;
          default:                             r_v_state <= StActive;
        endcase
      end

      // Decode of the current counter value, so outputs lag the counters by one.
      r_x           <= r_h_cnt;
      r_y           <= r_v_cnt;
      r_hsync       <= (r_h_state == StSync) ? H_SYNC_POL : ~H_SYNC_POL;
      r_vsync       <= (r_v_state == StSync) ? V_SYNC_POL : ~V_SYNC_POL;
      r_de          <= (r_h_state == StActive) && (r_v_state == StActive);
      r_line_start  <= (r_h_cnt == 11'd0);
      r_frame_start <= w_frame_start;
      if (w_frame_start) begin
        r_frame_count <= r_frame_count + 8'd1;
      end
    end
  end

  assign vga.xPosition     = r_x;
  assign vga.yPosition     = r_y;
  assign vga.hSync         = r_hsync;
  assign vga.vSync         = r_vsync;
  assign vga.displayEnable = r_de;
  assign vga.lineStart     = r_line_start;
  assign vga.frameStart    = r_frame_start;
  assign vga.frameCount    = r_frame_count;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 800x600 timing for reset and one-line checks, plus a
// tiny-parameter, inverted-polarity instance checked against a counter model.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_big_n;
  logic rst_small_n;

  vga_timing_if u_big_if ();
  vga_timing_if u_small_if ();

  vga_timing_gen u_big (
    .pixelClock (clk),
    .Reset      (rst_big_n),
    .vga        (u_big_if)
  );

  vga_timing_gen #(
    .H_VISIBLE  (8),
    .H_FRONT    (2),
    .H_SYNC     (2),
    .H_BACK     (2),
    .V_VISIBLE  (4),
    .V_FRONT    (1),
    .V_SYNC     (1),
    .V_BACK     (1),
    .H_SYNC_POL (1'b0),
    .V_SYNC_POL (1'b0)
  ) u_small (
    .pixelClock (clk),
    .Reset      (rst_small_n),
    .vga        (u_small_if)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_big_reset(input string tag);
    check({tag, "_x"},  32'(u_big_if.xPosition), 0);
    check({tag, "_y"},  32'(u_big_if.yPosition), 0);
    check({tag, "_hs"}, 32'(u_big_if.hSync), 0);
    check({tag, "_vs"}, 32'(u_big_if.vSync), 0);
    check({tag, "_de"}, 32'(u_big_if.displayEnable), 0);
    check({tag, "_ls"}, 32'(u_big_if.lineStart), 0);
    check({tag, "_fs"}, 32'(u_big_if.frameStart), 0);
    check({tag, "_fc"}, 32'(u_big_if.frameCount), 0);
  endtask

  int          hs_cnt;
  int          hs_first;
  int          hs_last;
  int          ex;
  int          ey;
  logic [7:0]  efc;
  int          n_frames;
  int          vs_cnt;
  int          last_fs;
  logic        exp_fs;

  initial begin
    rst_big_n   = 1'b0;
    rst_small_n = 1'b0;
    #12;
    check_big_reset("por");
    check("por_small_hs", 32'(u_small_if.hSync), 1);
    check("por_small_vs", 32'(u_small_if.vSync), 1);

    // First edge after release shows pixel (0,0).
    @(negedge clk);
    rst_big_n = 1'b1;
    tick();
    check("rel_x",  32'(u_big_if.xPosition), 0);
    check("rel_y",  32'(u_big_if.yPosition), 0);
    check("rel_de", 32'(u_big_if.displayEnable), 1);
    check("rel_ls", 32'(u_big_if.lineStart), 1);
    check("rel_fs", 32'(u_big_if.frameStart), 1);
    check("rel_fc", 32'(u_big_if.frameCount), 1);
    check("rel_hs", 32'(u_big_if.hSync), 0);

    // Asynchronous reset in the middle of a line, observed before any edge.
    repeat (500) tick();
    check("mid_x", 32'(u_big_if.xPosition), 500);
    check("mid_ls", 32'(u_big_if.lineStart), 0);
    #2;
    rst_big_n = 1'b0;
    #1;
    check_big_reset("async");
    @(negedge clk);
    rst_big_n = 1'b1;
    tick();
    check("rel2_x",  32'(u_big_if.xPosition), 0);
    check("rel2_y",  32'(u_big_if.yPosition), 0);
    check("rel2_fs", 32'(u_big_if.frameStart), 1);
    check("rel2_fc", 32'(u_big_if.frameCount), 1);

    // One full line plus the first pixel of the next.
    hs_cnt   = 0;
    hs_first = -1;
    hs_last  = -1;
    for (int k = 0; k <= 1056; k++) begin
      ex = k % 1056;
      ey = k / 1056;
      check("line_x",  32'(u_big_if.xPosition), 32'(ex));
      check("line_y",  32'(u_big_if.yPosition), 32'(ey));
      check("line_ls", 32'(u_big_if.lineStart), 32'(ex == 0));
      check("line_fs", 32'(u_big_if.frameStart), 32'(ex == 0 && ey == 0));
      check("line_de", 32'(u_big_if.displayEnable), 32'(ex < 800));
      check("line_hs", 32'(u_big_if.hSync), 32'(ex >= 840 && ex <= 967));
      check("line_vs", 32'(u_big_if.vSync), 0);
      check("line_fc", 32'(u_big_if.frameCount), 1);
      if (k < 1056 && u_big_if.hSync) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = ex;
        hs_last = ex;
      end
      tick();
    end
    check("hs_width", 32'(hs_cnt), 128);
    check("hs_first", 32'(hs_first), 840);
    check("hs_last",  32'(hs_last), 967);

    // Small timing: 14 x 7 = 98 pixels per frame, run past 256 frames.
    @(negedge clk);
    rst_small_n = 1'b1;
    tick();
    ex       = 0;
    ey       = 0;
    efc      = 8'd0;
    n_frames = 0;
    vs_cnt   = 0;
    last_fs  = -1;
    for (int c = 0; c < 256 * 98 + 4; c++) begin
      exp_fs = (ex == 0 && ey == 0);
      if (exp_fs) begin
        if (n_frames > 0) check("s_vs_width", 32'(vs_cnt), 14);
        vs_cnt = 0;
        n_frames++;
        efc = efc + 8'd1;
        if (n_frames == 256) check("s_fc_wrap", 32'(u_small_if.frameCount), 0);
      end
      check("s_x",  32'(u_small_if.xPosition), 32'(ex));
      check("s_y",  32'(u_small_if.yPosition), 32'(ey));
      check("s_de", 32'(u_small_if.displayEnable), 32'(ex < 8 && ey < 4));
      check("s_hs", 32'(u_small_if.hSync), 32'(!(ex >= 10 && ex <= 11)));
      check("s_vs", 32'(u_small_if.vSync), 32'(ey != 5));
      check("s_ls", 32'(u_small_if.lineStart), 32'(ex == 0));
      check("s_fs", 32'(u_small_if.frameStart), 32'(exp_fs));
      check("s_fc", 32'(u_small_if.frameCount), 32'(efc));
      if (!u_small_if.vSync) vs_cnt++;
      if (u_small_if.frameStart) begin
        if (last_fs >= 0) check("s_fs_period", 32'(c - last_fs), 98);
        last_fs = c;
      end
      if (ex == 13) begin
        ex = 0;
        ey = (ey == 6) ? 0 : ey + 1;
      end else begin
        ex++;
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
